axis_packet_mux: RTL

//   Datapath stage downstream of the round-robin arbiter in the stream crossbar.

---
 rtl/axis_packet_mux.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axis_packet_mux.sv
// Packet-locked stream mux: holds the granted input for a whole packet and
// forwards its beats through a 2-entry registered buffer to one master port.
module axis_packet_mux #(
  parameter int NUM_REQUEST  = 2,
  parameter int T_DATA_WIDTH = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQUEST*T_DATA_WIDTH-1:0] s_tdata_i,
  input  logic [NUM_REQUEST-1:0]              s_tvalid_i,
  input  logic [NUM_REQUEST-1:0]              s_tlast_i,
  output logic [NUM_REQUEST-1:0]              s_tready_o,
  output logic [NUM_REQUEST-1:0]              request_o,
  output logic [NUM_REQUEST-1:0]              s_last_o,
  input  logic [NUM_REQUEST-1:0]              grant_i,
  output logic [T_DATA_WIDTH-1:0]             m_tdata_o,
  output logic                                m_tvalid_o,
  output logic                                m_tlast_o,
  input  logic                                m_tready_i,
  output logic [CNT_WIDTH-1:0]                pkt_cnt_o
);

  localparam int SEL_W = $clog2(NUM_REQUEST);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                  state, state_next;
  logic [SEL_W-1:0]        sel, sel_next;
  logic [T_DATA_WIDTH-1:0] in_data, head_data, tail_data;
  logic                    in_valid, in_last, head_last, tail_last;
  logic [1:0]              count;
  logic [CNT_WIDTH-1:0]    pkt_cnt;
  logic                    full, push, pop;

  // Slave handshake: a beat moves when s_tvalid_i[sel] and s_tready_o[sel]
  // are both high at a posedge; master beat moves on m_tvalid_o & m_tready_i.
  always_comb begin
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < NUM_REQUEST; k++) begin
      if (sel == SEL_W'(k)) begin
        in_data  = s_tdata_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
        in_valid = s_tvalid_i[k];
        in_last  = s_tlast_i[k];
      end
    end
  end

  // Ready only looks at local occupancy, never at m_tready_i.
  assign full = (count == 2'd2);
  assign push = (state == LOCK) && in_valid && !full;
  assign pop  = (count != 2'd0) && m_tready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    case (state)
      IDLE: begin
        if (|grant_i) begin
          state_next = LOCK;
          for (int k = NUM_REQUEST - 1; k >= 0; k--) begin
            if (grant_i[k]) sel_next = SEL_W'(k);
          end
        end
      end
      LOCK: begin
        if (push && in_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_tready_o = '0;
    s_last_o   = '0;
    if (state == LOCK) begin
      s_tready_o[sel] = !full;
      s_last_o[sel]   = push && in_last;
    end
  end

  // Head always holds the oldest beat; tail is only occupied at count 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= in_data;
            head_last <= in_last;
          end else begin
            tail_data <= in_data;
            tail_last <= in_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= in_data;
            head_last <= in_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= in_data;
            tail_last <= in_last;
          end
        end
        default: ;
      endcase
      if (pop && head_last) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  assign request_o  = s_tvalid_i;
  assign m_tdata_o  = head_data;
  assign m_tlast_o  = head_last;
  assign m_tvalid_o = (count != 2'd0);
  assign pkt_cnt_o  = pkt_cnt;

endmodule
